dm_lane_ram: RTL and testbench

Parametrised data memory for the MIPS MEM stage with byte/halfword/word stores and loads, sign/zero extension on loads, and address-exception flags. It generalises the fixed 12 KiB word-only data memory. A hardware sweep-clear state machine zeroes the array after reset, so no single-cycle whole-array reset is needed. The memory sits between the ALU address result and the write-back mux.

---
 rtl/dm_pkg.sv | 15 +
 rtl/dm_lane_align.sv | 50 +++++
 rtl/dm_lane_ram.sv | 123 ++++++++++++
 tb/tb_dm_lane_ram.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the lane-addressed data memory: access sizes and
// the sweep-clear controller states.
package dm_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } dm_state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for one 32-bit memory word: store byte enables and
// replicated store data, load lane select with extension, alignment check.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  a_lo,
   input  logic [31:0] d,
   input  logic [31:0] raw,
   input  logic        load_signed,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        misaligned
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      be         = 4'b0000;
      wdata      = d;
      rdata      = '0;
      misaligned = 1'b0;
      byte_v     = raw[{a_lo, 3'b000} +: 8];
      half_v     = a_lo[1] ? raw[31:16] : raw[15:0];
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << a_lo;
            wdata = {4{d[7:0]}};
            rdata = {{24{load_signed & byte_v[7]}}, byte_v};
         end
         SZ_HALF: begin
            misaligned = a_lo[0];
            be         = a_lo[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{d[15:0]}};
            rdata      = {{16{load_signed & half_v[15]}}, half_v};
         end
         SZ_WORD: begin
            misaligned = (a_lo != 2'b00);
            be         = 4'b1111;
            rdata      = raw;
         end
         default: begin
            misaligned = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/dm_lane_ram.sv
// MEM-stage data memory with byte/half/word access, load extension,
// address-exception flags and a post-reset sweep that zeroes the array.
module dm_lane_ram
   import dm_pkg::*;
#(
   parameter int          DEPTH_WORDS    = 3072,
   parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        RE,
   input  logic        WE,
   input  logic [1:0]  SIZE,
   input  logic        LOAD_SIGNED,
   input  logic [31:0] A,
   input  logic [31:0] D,
   output logic [31:0] Q,
   output logic        BUSY,
   output logic        ADEL,
   output logic        ADES
);

   localparam int              CW       = $clog2(DEPTH_WORDS);
   localparam logic [CW-1:0]   LAST_IDX = CW'(DEPTH_WORDS - 1);
   localparam logic [32:0]     LIMIT    = 33'(DEPTH_WORDS) << 2;

   logic [31:0]   mem [DEPTH_WORDS];

   dm_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [31:0]   offset;
   logic          in_range;
   logic [CW-1:0] acc_idx;
   logic [31:0]   raw;
   logic [3:0]    lane_be;
   logic [31:0]   lane_wdata;
   logic [31:0]   lane_rdata;
   logic          misaligned;
   logic          bad;
   logic          busy;
   logic          blocked;

   logic [3:0]    wr_be;
   logic [31:0]   wr_data;
   logic [CW-1:0] wr_idx;

   // Unsigned subtract folds "below base" into the same upper-bound compare.
   assign offset   = A - ADDR_BASE;
   assign in_range = ({1'b0, offset} < LIMIT);
   assign acc_idx  = in_range ? offset[CW+1:2] : '0;
   assign raw      = mem[acc_idx];

   dm_lane_align u_align (
      .size        (SIZE),
      .a_lo        (A[1:0]),
      .d           (D),
      .raw         (raw),
      .load_signed (LOAD_SIGNED),
      .be          (lane_be),
      .wdata       (lane_wdata),
      .rdata       (lane_rdata),
      .misaligned  (misaligned)
   );

   assign bad     = ~in_range | misaligned;
   assign busy    = (state_q == ST_CLEAR);
   assign blocked = busy | RESET;

   always_comb begin
      BUSY = busy;
      ADEL = RE & bad & ~blocked;
      ADES = WE & bad & ~blocked;
      Q    = (bad | blocked) ? 32'h0 : lane_rdata;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_CLEAR) begin
         if (cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Single byte-enabled write port shared by the sweep and by stores.
   always_comb begin
      wr_be   = 4'b0000;
      wr_data = '0;
      wr_idx  = acc_idx;
      if (busy) begin
         wr_be  = RESET ? 4'b0000 : 4'b1111;
         wr_idx = cnt_q;
      end else if (WE && !bad && !RESET) begin
         wr_be   = lane_be;
         wr_data = lane_wdata;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_be[i]) begin
            mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dm_lane_ram.sv
// Self-checking bench for dm_lane_ram: clear sweep, directed vector table,
// randomized accesses against a byte-array reference, reset mid-sweep.
module tb_dm_lane_ram;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          NBYTE = DEPTH * 4;

   logic        clk;
   logic        rst;
   logic        re, we, sgn;
   logic [1:0]  sz;
   logic [31:0] a, d;
   logic [31:0] q;
   logic        busy, adel, ades;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] mb [NBYTE];

   dm_lane_ram #(
      .DEPTH_WORDS    (DEPTH),
      .ADDR_BASE      (BASE),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk         (clk),
      .RESET       (rst),
      .RE          (re),
      .WE          (we),
      .SIZE        (sz),
      .LOAD_SIGNED (sgn),
      .A           (a),
      .D           (d),
      .Q           (q),
      .BUSY        (busy),
      .ADEL        (adel),
      .ADES        (ades)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        we;
      logic        re;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] q;
      logic        adel;
      logic        ades;
   } vec_t;

   vec_t tbl [22];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
   endtask

   function automatic logic model_bad(input logic [31:0] aa, input logic [1:0] s);
      logic [31:0] off;
      off = aa - BASE;
      return (off >= NBYTE) || (s == 2'd3) || (s == 2'd1 && aa[0]) ||
             (s == 2'd2 && aa[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] model_q(input logic [31:0] aa, input logic [1:0] s,
                                           input logic g);
      int          o;
      logic [31:0] v;
      if (model_bad(aa, s)) return 32'h0;
      o = int'(aa - BASE);
      v = 32'h0;
      case (s)
         2'd0: begin
            v = {24'h0, mb[o]};
            if (g && mb[o][7]) v = v | 32'hFFFF_FF00;
         end
         2'd1: begin
            v = {16'h0, mb[o+1], mb[o]};
            if (g && mb[o+1][7]) v = v | 32'hFFFF_0000;
         end
         default: v = {mb[o+3], mb[o+2], mb[o+1], mb[o]};
      endcase
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
   endtask

   task automatic drive(input logic w, input logic r, input logic [1:0] s, input logic g,
                        input logic [31:0] aa, input logic [31:0] dd);
      @(negedge clk);
      we = w; re = r; sz = s; sgn = g; a = aa; d = dd;
      #1;
   endtask

   task automatic tick_model();
      int o;
      if (we && !model_bad(a, sz)) begin
         o = int'(a - BASE);
         for (int i = 0; i < (1 << sz); i++) mb[o+i] = d[8*i +: 8];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         n++;
         if (!busy) break;
      end
   endtask

   task automatic read_all_zero(input string nm);
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 1'b1, 2'd2, 1'b0, BASE + 32'(4*i), 32'h0);
         chk(nm, q, 32'h0);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic r, input logic [1:0] s,
                               input logic g, input logic [31:0] aa, input logic [31:0] dd,
                               input logic [31:0] qq, input logic el, input logic es);
      vec_t v;
      v.we = w; v.re = r; v.sz = s; v.sg = g; v.a = aa; v.d = dd;
      v.q = qq; v.adel = el; v.ades = es;
      return v;
   endfunction

   initial begin
      int          n;
      logic [31:0] ra;
      logic [1:0]  rs;

      tbl[0]  = mk(1, 0, 2'd2, 0, 32'h1000, 32'h1122_3344, 32'h0000_0000, 0, 0);
      tbl[1]  = mk(0, 1, 2'd2, 0, 32'h1000, 32'h0,         32'h1122_3344, 0, 0);
      tbl[2]  = mk(1, 0, 2'd0, 0, 32'h1002, 32'h0000_00F0, 32'h0000_0022, 0, 0);
      tbl[3]  = mk(0, 1, 2'd2, 0, 32'h1000, 32'h0,         32'h11F0_3344, 0, 0);
      tbl[4]  = mk(0, 1, 2'd0, 1, 32'h1002, 32'h0,         32'hFFFF_FFF0, 0, 0);
      tbl[5]  = mk(0, 1, 2'd0, 0, 32'h1002, 32'h0,         32'h0000_00F0, 0, 0);
      tbl[6]  = mk(1, 0, 2'd2, 0, 32'h1004, 32'hCAFE_5A5A, 32'h0000_0000, 0, 0);
      tbl[7]  = mk(1, 1, 2'd1, 1, 32'h1006, 32'h1234_8001, 32'hFFFF_CAFE, 0, 0);
      tbl[8]  = mk(0, 1, 2'd1, 1, 32'h1006, 32'h0,         32'hFFFF_8001, 0, 0);
      tbl[9]  = mk(0, 1, 2'd1, 0, 32'h1004, 32'h0,         32'h0000_5A5A, 0, 0);
      tbl[10] = mk(0, 1, 2'd2, 0, 32'h1004, 32'h0,         32'h8001_5A5A, 0, 0);
      tbl[11] = mk(0, 1, 2'd1, 0, 32'h1005, 32'h0,         32'h0000_0000, 1, 0);
      tbl[12] = mk(1, 0, 2'd2, 0, 32'h1040, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1);
      tbl[13] = mk(0, 1, 2'd2, 0, 32'h0FFC, 32'h0,         32'h0000_0000, 1, 0);
      tbl[14] = mk(1, 0, 2'd2, 0, 32'h103C, 32'hDEAD_BEEF, 32'h0000_0000, 0, 0);
      tbl[15] = mk(0, 1, 2'd2, 0, 32'h103C, 32'h0,         32'hDEAD_BEEF, 0, 0);
      tbl[16] = mk(1, 1, 2'd3, 0, 32'h1000, 32'h0,         32'h0000_0000, 1, 1);
      tbl[17] = mk(0, 1, 2'd2, 0, 32'h1000, 32'h0,         32'h11F0_3344, 0, 0);
      tbl[18] = mk(0, 1, 2'd1, 1, 32'h1002, 32'h0,         32'h0000_11F0, 0, 0);
      tbl[19] = mk(0, 1, 2'd0, 1, 32'h1003, 32'h0,         32'h0000_0011, 0, 0);
      tbl[20] = mk(1, 0, 2'd0, 0, 32'h103F, 32'h0000_0080, 32'h0000_00DE, 0, 0);
      tbl[21] = mk(0, 1, 2'd0, 1, 32'h103F, 32'h0,         32'hFFFF_FF80, 0, 0);

      // Reset state with a valid load address and an out-of-range store.
      rst = 1'b1; we = 1'b1; re = 1'b1; sz = 2'd2; sgn = 1'b0;
      a = BASE; d = 32'hFFFF_FFFF;
      #2;
      chk("rst_busy", {31'h0, busy}, 32'h1);
      chk("rst_q", q, 32'h0);
      a = 32'h0;
      #1;
      chk("rst_adel", {31'h0, adel}, 32'h0);
      chk("rst_ades", {31'h0, ades}, 32'h0);

      // Clear sweep while a valid store is held on the inputs.
      @(negedge clk);
      a = BASE;
      rst = 1'b0;
      #1;
      chk("clr_ades", {31'h0, ades}, 32'h0);
      chk("clr_q", q, 32'h0);
      count_busy(n);
      we = 1'b0;
      chk("busy_len", 32'(n), 32'(DEPTH));
      model_clear();
      read_all_zero("clr_read");

      foreach (tbl[i]) begin
         drive(tbl[i].we, tbl[i].re, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].d);
         chk($sformatf("vec%0d_q", i), q, tbl[i].q);
         chk($sformatf("vec%0d_adel", i), {31'h0, adel}, {31'h0, tbl[i].adel});
         chk($sformatf("vec%0d_ades", i), {31'h0, ades}, {31'h0, tbl[i].ades});
         tick_model();
      end

      for (int i = 0; i < 300; i++) begin
         ra = BASE - 32'd8 + 32'($urandom_range(0, 79));
         rs = 2'($urandom_range(0, 3));
         drive(1'($urandom), 1'($urandom), rs, 1'($urandom), ra, $urandom);
         chk($sformatf("rnd%0d_q", i), q, model_q(a, sz, sgn));
         chk($sformatf("rnd%0d_adel", i), {31'h0, adel},
             {31'h0, re & model_bad(a, sz)});
         chk($sformatf("rnd%0d_ades", i), {31'h0, ades},
             {31'h0, we & model_bad(a, sz)});
         tick_model();
      end

      // Reset asserted between edges part-way through a sweep.
      drive(1'b0, 1'b1, 2'd2, 1'b0, BASE + 32'h10, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("mid_busy_pre", {31'h0, busy}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_busy_rst", {31'h0, busy}, 32'h1);
      chk("mid_q_rst", q, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      count_busy(n);
      chk("mid_busy_len", 32'(n), 32'(DEPTH));
      model_clear();
      read_all_zero("mid_read");

      // First store right after the sweep commits and reads back.
      drive(1'b1, 1'b0, 2'd2, 1'b0, BASE + 32'h8, 32'hA5A5_0F0F);
      tick_model();
      drive(1'b0, 1'b1, 2'd2, 1'b0, BASE + 32'h8, 32'h0);
      chk("post_store", q, model_q(a, sz, sgn));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
